// File: rtl/scan_pkg.sv
// Shared constants and state type for the channel scan sequencer.
package scan_pkg;

   localparam int CH_W = 3;
   localparam int NCH  = 8;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      DONE
   } state_e;

endpackage

// File: rtl/scan_sequencer_next_enabled_ch.sv
// Finds the next enabled channel above cur and the lowest enabled channel.
module next_enabled_ch
   import scan_pkg::*;
(
   input  logic [NCH-1:0]  mask,
   input  logic [CH_W-1:0] cur,
   output logic [CH_W-1:0] nxt,
   output logic            has_nxt,
   output logic [CH_W-1:0] low,
   output logic            any
);

   always_comb begin
      nxt     = '0;
      has_nxt = 1'b0;
      low     = '0;
      // Descending walk so the last hit is the closest one.
      for (int i = NCH - 1; i >= 0; i--) begin
         if (mask[i] && (i > int'(cur))) begin
            nxt     = CH_W'(i);
            has_nxt = 1'b1;
         end
         if (mask[i]) begin
            low = CH_W'(i);
         end
      end
      any = |mask;
   end

endmodule

// File: rtl/scan_sequencer.sv
// Walks decoder select S over the masked channels with a per-channel dwell.
module scan_sequencer
   import scan_pkg::*;
#(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               mode,
   input  logic [NCH-1:0]     mask,
   input  logic [DWELL_W-1:0] dwell,
   output logic [CH_W-1:0]    S,
   output logic               E,
   output logic               busy,
   output logic               done,
   output logic               wrap
);

   state_e               state_q, state_d;
   logic [CH_W-1:0]      s_q, s_d;
   logic                 e_q, e_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 wrap_q, wrap_d;
   logic [NCH-1:0]       mask_q, mask_d;
   logic                 mode_q, mode_d;
   logic [DWELL_W-1:0]   dwell_q, dwell_d;
   logic [DWELL_W-1:0]   cnt_q, cnt_d;

   logic [NCH-1:0]       mask_sel;
   logic [DWELL_W-1:0]   dwell_eff;
   logic [CH_W-1:0]      ch_nxt;
   logic [CH_W-1:0]      ch_low;
   logic                 ch_has_nxt;
   logic                 ch_any;

   // In IDLE the live mask picks the first channel; afterwards the latched one.
   assign mask_sel  = (state_q == IDLE) ? mask : mask_q;
   assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

   next_enabled_ch u_next (
      .mask    (mask_sel),
      .cur     (s_q),
      .nxt     (ch_nxt),
      .has_nxt (ch_has_nxt),
      .low     (ch_low),
      .any     (ch_any)
   );

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      e_d     = e_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      wrap_d  = 1'b0;
      mask_d  = mask_q;
      mode_d  = mode_q;
      dwell_d = dwell_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start && !stop) begin
               mask_d  = mask;
               mode_d  = mode;
               dwell_d = dwell_eff;
               if (ch_any) begin
                  state_d = ACTIVE;
                  s_d     = ch_low;
                  e_d     = 1'b1;
                  busy_d  = 1'b1;
                  cnt_d   = dwell_eff - DWELL_W'(1);
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end
         ACTIVE: begin
            if (stop) begin
               state_d = IDLE;
               e_d     = 1'b0;
               busy_d  = 1'b0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - DWELL_W'(1);
            end else if (ch_has_nxt) begin
               s_d   = ch_nxt;
               cnt_d = dwell_q - DWELL_W'(1);
            end else if (mode_q) begin
               s_d    = ch_low;
               wrap_d = 1'b1;
               cnt_d  = dwell_q - DWELL_W'(1);
            end else begin
               state_d = DONE;
               e_d     = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         s_q     <= '0;
         e_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
         mask_q  <= '0;
         mode_q  <= 1'b0;
         dwell_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         e_q     <= e_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
         mask_q  <= mask_d;
         mode_q  <= mode_d;
         dwell_q <= dwell_d;
         cnt_q   <= cnt_d;
      end
   end

   assign S    = s_q;
   assign E    = e_q;
   assign busy = busy_q;
   assign done = done_q;
   assign wrap = wrap_q;

endmodule
